// File: rtl/sle_cfg_pkg.sv
// rtl/sle_cfg_pkg.sv - shared types and constants for the SLE configuration sequencer
package sle_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    localparam int SETTLE_CW = 4;

endpackage

// File: rtl/sle_cfg_shreg.sv
// rtl/sle_cfg_shreg.sv - parallel-load MSB-out shift register with bit counter
module sle_cfg_shreg #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Rstn,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         shift_i,
    output logic         msb_o,
    output logic         last_o
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    logic [W-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shreg_d = data_i;
            cnt_d   = '0;
        end else if (shift_i) begin
            shreg_d = {shreg_q[W-2:0], 1'b0};
            cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign msb_o = shreg_q[W-1];
    // High during the cycle whose closing edge performs the W-th shift.
    assign last_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/sle_cfg_seq.sv
// rtl/sle_cfg_seq.sv - serial configuration sequencer driving a daisy-chained SLE bank
module sle_cfg_seq
    import sle_cfg_pkg::*;
#(
    parameter int W      = 8,
    parameter int SETTLE = 1
) (
    input  logic         Clk,
    input  logic         Rstn,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_data,
    output logic         cfg_ready,
    input  logic         func_en,
    output logic         func_stall,
    output logic         chain_en,
    output logic         chain_sln,
    output logic         chain_sd,
    output logic         busy,
    output logic         done
);

    localparam logic [SETTLE_CW-1:0] SETTLE_LAST = SETTLE_CW'((SETTLE > 0) ? SETTLE - 1 : 0);

    state_e                 state_q, state_d;
    logic [SETTLE_CW-1:0]   settle_q, settle_d;
    logic                   done_q, done_d;
    logic                   load;
    logic                   shift;
    logic                   sh_msb;
    logic                   sh_last;

    sle_cfg_shreg #(
        .W (W)
    ) u_shreg (
        .Clk     (Clk),
        .Rstn    (Rstn),
        .load_i  (load),
        .data_i  (cfg_data),
        .shift_i (shift),
        .msb_o   (sh_msb),
        .last_o  (sh_last)
    );

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        done_d   = 1'b0;
        load     = 1'b0;
        shift    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift = 1'b1;
                if (sh_last) begin
                    settle_d = '0;
                    if (SETTLE == 0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    settle_d = settle_q + SETTLE_CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            done_q   <= done_d;
        end
    end

    // The bank sees func_en only while idle; the sequencer owns En otherwise.
    always_comb begin
        cfg_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        chain_en  = func_en;
        chain_sln = 1'b1;
        chain_sd  = 1'b0;
        case (state_q)
            ST_SHIFT: begin
                chain_en  = 1'b1;
                chain_sln = 1'b0;
                chain_sd  = sh_msb;
            end
            ST_SETTLE: chain_en = 1'b0;
            default: ;
        endcase
        func_stall = func_en & busy;
    end

    assign done = done_q;

endmodule

// File: tb/tb_sle_cfg_seq.sv
// tb/tb_sle_cfg_seq.sv - directed bench for sle_cfg_seq with an SLE chain load model
module tb_sle_cfg_seq;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Rstn = 1'b0;
    logic         cfg_valid_a = 1'b0;
    logic         cfg_valid_b = 1'b0;
    logic [W-1:0] cfg_data = '0;
    logic         func_en = 1'b0;
    logic [W-1:0] chain_d = '0;

    logic cfg_ready_a, func_stall_a, chain_en_a, chain_sln_a, chain_sd_a, busy_a, done_a;
    logic cfg_ready_b, func_stall_b, chain_en_b, chain_sln_b, chain_sd_b, busy_b, done_b;

    logic [W-1:0] q_a = '0;
    logic [W-1:0] q_b = '0;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    sle_cfg_seq #(.W(W), .SETTLE(1)) dut_a (
        .Clk        (Clk),
        .Rstn       (Rstn),
        .cfg_valid  (cfg_valid_a),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready_a),
        .func_en    (func_en),
        .func_stall (func_stall_a),
        .chain_en   (chain_en_a),
        .chain_sln  (chain_sln_a),
        .chain_sd   (chain_sd_a),
        .busy       (busy_a),
        .done       (done_a)
    );

    sle_cfg_seq #(.W(W), .SETTLE(0)) dut_b (
        .Clk        (Clk),
        .Rstn       (Rstn),
        .cfg_valid  (cfg_valid_b),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready_b),
        .func_en    (func_en),
        .func_stall (func_stall_b),
        .chain_en   (chain_en_b),
        .chain_sln  (chain_sln_b),
        .chain_sd   (chain_sd_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    // SLE bank in flip-flop mode: element W-1 takes SD from the sequencer, element i from Q[i+1].
    always @(posedge Clk) begin
        if (chain_en_a) q_a <= chain_sln_a ? chain_d : {chain_sd_a, q_a[W-1:1]};
        if (chain_en_b) q_b <= chain_sln_b ? chain_d : {chain_sd_b, q_b[W-1:1]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic smp();
        @(negedge Clk);
    endtask

    initial begin
        logic [W-1:0] pat;
        int first_done;
        int second_done;
        int ndone;

        // Reset with func_en high
        func_en = 1'b1;
        #2;
        chk("rst_ready",  32'(cfg_ready_a),  32'd1);
        chk("rst_busy",   32'(busy_a),       32'd0);
        chk("rst_en",     32'(chain_en_a),   32'd1);
        chk("rst_sln",    32'(chain_sln_a),  32'd1);
        chk("rst_sd",     32'(chain_sd_a),   32'd0);
        chk("rst_done",   32'(done_a),       32'd0);
        chk("rst_stall",  32'(func_stall_a), 32'd0);
        chk("rst_b_busy", 32'(busy_b),       32'd0);

        tick();
        Rstn    = 1'b1;
        func_en = 1'b0;
        tick();

        // Basic load of A5
        pat = 8'hA5;
        cfg_data = pat;
        cfg_valid_a = 1'b1;
        tick();
        cfg_valid_a = 1'b0;
        for (int k = 1; k <= W; k++) begin
            smp();
            chk($sformatf("basic_sd_c%0d", k), 32'(chain_sd_a), 32'(pat[W-k]));
            chk($sformatf("basic_sln_c%0d", k), 32'(chain_sln_a), 32'd0);
            chk($sformatf("basic_en_c%0d", k), 32'(chain_en_a), 32'd1);
            tick();
        end
        smp();
        chk("basic_c9_busy", 32'(busy_a),     32'd1);
        chk("basic_c9_done", 32'(done_a),     32'd0);
        chk("basic_c9_en",   32'(chain_en_a), 32'd0);
        chk("basic_c9_sln",  32'(chain_sln_a), 32'd1);
        tick();
        smp();
        chk("basic_c10_done",  32'(done_a),      32'd1);
        chk("basic_c10_ready", 32'(cfg_ready_a), 32'd1);
        chk("basic_chain",     32'(q_a),         32'h0000_00A5);
        tick();
        smp();
        chk("basic_c11_done", 32'(done_a), 32'd0);

        // Enable arbitration with random functional data
        tick();
        func_en = 1'b1;
        chain_d = W'($urandom);
        cfg_data = 8'h3C;
        cfg_valid_a = 1'b1;
        tick();
        cfg_valid_a = 1'b0;
        for (int k = 1; k <= W + 1; k++) begin
            chain_d = W'($urandom);
            smp();
            chk($sformatf("arb_stall_c%0d", k), 32'(func_stall_a), 32'd1);
            tick();
        end
        smp();
        chk("arb_c10_stall", 32'(func_stall_a), 32'd0);
        chk("arb_c10_en",    32'(chain_en_a),   32'd1);
        chk("arb_c10_done",  32'(done_a),       32'd1);
        chk("arb_chain",     32'(q_a),          32'h0000_003C);
        tick();
        func_en = 1'b0;
        tick();

        // Back-to-back with cfg_valid held
        cfg_data = 8'h3C;
        cfg_valid_a = 1'b1;
        first_done = 0;
        second_done = 0;
        tick();
        for (int c = 1; c <= 20; c++) begin
            if (c == 10) cfg_data = 8'hC3;
            if (c == 11) cfg_valid_a = 1'b0;
            smp();
            if (c == 5)  chk("b2b_busy_ready", 32'(cfg_ready_a), 32'd0);
            if (c == 10) chk("b2b_done_ready", 32'(cfg_ready_a), 32'd1);
            if (c == 11) chk("b2b_second_busy", 32'(busy_a), 32'd1);
            if (c == 20) chk("b2b_chain", 32'(q_a), 32'h0000_00C3);
            if (done_a) begin
                if (first_done == 0) first_done = c;
                else second_done = c;
            end
            tick();
        end
        chk("b2b_first_done",  32'(first_done),  32'd10);
        chk("b2b_second_done", 32'(second_done), 32'd20);

        // Reset after four shifts
        cfg_data = 8'h5A;
        cfg_valid_a = 1'b1;
        tick();
        cfg_valid_a = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        func_en = 1'b1;
        smp();
        chk("mid_pre_stall", 32'(func_stall_a), 32'd1);
        #1;
        Rstn = 1'b0;
        #1;
        chk("mid_busy",  32'(busy_a),       32'd0);
        chk("mid_ready", 32'(cfg_ready_a),  32'd1);
        chk("mid_sln",   32'(chain_sln_a),  32'd1);
        chk("mid_sd",    32'(chain_sd_a),   32'd0);
        chk("mid_stall", 32'(func_stall_a), 32'd0);
        chk("mid_en",    32'(chain_en_a),   32'd1);
        chk("mid_done",  32'(done_a),       32'd0);
        tick();
        Rstn = 1'b1;
        func_en = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            smp();
            if (done_a) ndone++;
            tick();
        end
        chk("mid_no_done", 32'(ndone), 32'd0);
        cfg_data = 8'hFF;
        cfg_valid_a = 1'b1;
        tick();
        cfg_valid_a = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            smp();
            if (c == 10) begin
                chk("reload_done",  32'(done_a), 32'd1);
                chk("reload_chain", 32'(q_a),    32'h0000_00FF);
            end
            tick();
        end

        // SETTLE=0 variant
        cfg_data = 8'h81;
        cfg_valid_b = 1'b1;
        tick();
        cfg_valid_b = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            smp();
            if (c == 8) begin
                chk("s0_c8_done", 32'(done_b), 32'd0);
                chk("s0_c8_busy", 32'(busy_b), 32'd1);
            end
            if (c == 9) begin
                chk("s0_c9_done",  32'(done_b),      32'd1);
                chk("s0_c9_ready", 32'(cfg_ready_b), 32'd1);
                chk("s0_chain",    32'(q_b),         32'h0000_0081);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
